loot_field_ctrl: RTL and testbench

- Upstream feeder of the loot bitmap stage. Holds the position and type of every loot item on the current level.
- Per pixel, finds which loot tile (if any) covers the pixel and emits the loot type, tile-relative offsets and an inside flag, all registered.
- Also runs the hook grab sequence: scan for a hit, carry the grabbed item with the hook, then deliver and clear it.

---
 rtl/loot_pkg.sv | 31 +++
 rtl/loot_tile_hit.sv | 25 ++
 rtl/loot_field_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_loot_field_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/loot_pkg.sv
// Shared types and constants for the loot field: item types, slot record,
// grab FSM states and the tile geometry.
package loot_pkg;

    localparam int TILE_NUMBER_OF_X_BITS = 5;
    localparam int TILE_NUMBER_OF_Y_BITS = 5;

    typedef enum logic [2:0] {
        LOOT_NONE  = 3'd0,
        LOOT_GOLD  = 3'd1,
        LOOT_STONE = 3'd2
    } loot_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CARRY = 2'd2
    } loot_state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        loot_type_t  ltype;
    } loot_slot_t;

    // Saturating subtract, used to keep a carried tile on screen near x=0.
    function automatic logic [10:0] clamp_sub(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : 11'd0;
    endfunction

endpackage

// File: rtl/loot_tile_hit.sv
// Combinational containment test of one point against one loot tile,
// plus the tile-relative offsets of that point.
module loot_tile_hit #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5
) (
    input  logic [10:0] point_x,
    input  logic [10:0] point_y,
    input  logic [10:0] tile_x,
    input  logic [10:0] tile_y,
    input  logic [2:0]  tile_type,
    output logic        hit,
    output logic [10:0] off_x,
    output logic [10:0] off_y
);

    assign off_x = point_x - tile_x;
    assign off_y = point_y - tile_y;

    // Empty slots never match, whatever their stale coordinates are.
    assign hit = (tile_type != 3'd0)
              && (point_x >= tile_x) && ((off_x >> X_BITS) == 11'd0)
              && (point_y >= tile_y) && ((off_y >> Y_BITS) == 11'd0);

endmodule

// File: rtl/loot_field_ctrl.sv
// Loot slot store: per-pixel tile lookup (1 clk latency) and the hook
// grab sequence IDLE -> SCAN -> CARRY -> IDLE.
module loot_field_ctrl #(
    parameter int NUM_LOOTS             = 8,
    parameter int TILE_NUMBER_OF_X_BITS = loot_pkg::TILE_NUMBER_OF_X_BITS,
    parameter int TILE_NUMBER_OF_Y_BITS = loot_pkg::TILE_NUMBER_OF_Y_BITS
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        clear_all,
    input  logic        load_en,
    input  logic [3:0]  load_idx,
    input  logic [10:0] load_x,
    input  logic [10:0] load_y,
    input  logic [2:0]  load_type,
    input  logic        grab_req,
    input  logic [10:0] hookX,
    input  logic [10:0] hookY,
    input  logic        deliver,
    output logic [2:0]  loot_type,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        grab_hit,
    output logic        grab_miss,
    output logic [2:0]  grabbed_type,
    output logic        carrying,
    output logic        delivered,
    output logic [2:0]  delivered_type,
    output logic [4:0]  remaining
);
    import loot_pkg::*;

    localparam logic [10:0] HALF_TILE_W = 11'(1 << (TILE_NUMBER_OF_X_BITS - 1));
    localparam logic [3:0]  LAST_IDX    = 4'(NUM_LOOTS - 1);

    loot_slot_t  slots [NUM_LOOTS];
    loot_state_t state, state_next;
    logic [3:0]  scan_idx, carry_idx;
    logic [10:0] hook_lat_x, hook_lat_y;

    logic [NUM_LOOTS-1:0] pix_hit;
    logic [10:0] pix_off_x [NUM_LOOTS];
    logic [10:0] pix_off_y [NUM_LOOTS];
    logic        sel_hit;
    logic [2:0]  sel_type;
    logic [10:0] sel_off_x, sel_off_y;

    for (genvar g = 0; g < NUM_LOOTS; g++) begin : g_pix
        loot_tile_hit #(.X_BITS(TILE_NUMBER_OF_X_BITS), .Y_BITS(TILE_NUMBER_OF_Y_BITS)) u_pix_hit (
            .point_x(pixelX), .point_y(pixelY),
            .tile_x(slots[g].x), .tile_y(slots[g].y), .tile_type(slots[g].ltype),
            .hit(pix_hit[g]), .off_x(pix_off_x[g]), .off_y(pix_off_y[g])
        );
    end

    // Walk from the top so the lowest matching index is the one left standing.
    always_comb begin
        sel_hit   = 1'b0;
        sel_type  = 3'd0;
        sel_off_x = 11'd0;
        sel_off_y = 11'd0;
        for (int i = NUM_LOOTS - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                sel_hit   = 1'b1;
                sel_type  = slots[i].ltype;
                sel_off_x = pix_off_x[i];
                sel_off_y = pix_off_y[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            loot_type       <= 3'd0;
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
        end else begin
            InsideRectangle <= sel_hit;
            loot_type       <= sel_type;
            offsetX         <= sel_off_x;
            offsetY         <= sel_off_y;
        end
    end

    loot_slot_t  scan_slot;
    logic        scan_hit;
    logic [10:0] scan_off_x_unused, scan_off_y_unused;

    always_comb begin
        scan_slot = '0;
        for (int i = 0; i < NUM_LOOTS; i++)
            if (scan_idx == 4'(i)) scan_slot = slots[i];
    end

    loot_tile_hit #(.X_BITS(TILE_NUMBER_OF_X_BITS), .Y_BITS(TILE_NUMBER_OF_Y_BITS)) u_scan_hit (
        .point_x(hook_lat_x), .point_y(hook_lat_y),
        .tile_x(scan_slot.x), .tile_y(scan_slot.y), .tile_type(scan_slot.ltype),
        .hit(scan_hit), .off_x(scan_off_x_unused), .off_y(scan_off_y_unused)
    );

    logic do_load, do_grab, hit_fire, miss_fire, do_move, do_deliver;

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_grab    = 1'b0;
        hit_fire   = 1'b0;
        miss_fire  = 1'b0;
        do_move    = 1'b0;
        do_deliver = 1'b0;
        if (clear_all) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    do_load = load_en;
                    if (grab_req) begin
                        do_grab    = 1'b1;
                        state_next = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        hit_fire   = 1'b1;
                        state_next = ST_CARRY;
                    end else if (scan_idx == LAST_IDX) begin
                        miss_fire  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_CARRY: begin
                    if (deliver) begin
                        do_deliver = 1'b1;
                        state_next = ST_IDLE;
                    end else if (startOfFrame) begin
                        do_move = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    logic [4:0] occupied;

    always_comb begin
        occupied = 5'd0;
        for (int i = 0; i < NUM_LOOTS; i++)
            if (slots[i].ltype != LOOT_NONE) occupied = occupied + 5'd1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= ST_IDLE;
            scan_idx       <= 4'd0;
            carry_idx      <= 4'd0;
            hook_lat_x     <= 11'd0;
            hook_lat_y     <= 11'd0;
            grab_hit       <= 1'b0;
            grab_miss      <= 1'b0;
            grabbed_type   <= 3'd0;
            delivered      <= 1'b0;
            delivered_type <= 3'd0;
            remaining      <= 5'd0;
            for (int i = 0; i < NUM_LOOTS; i++) slots[i] <= '0;
        end else begin
            state          <= state_next;
            grab_hit       <= hit_fire;
            grab_miss      <= miss_fire;
            delivered      <= do_deliver;
            delivered_type <= do_deliver ? grabbed_type : 3'd0;
            remaining      <= occupied;
            if (state == ST_SCAN) scan_idx <= scan_idx + 4'd1;
            if (do_grab) begin
                hook_lat_x <= hookX;
                hook_lat_y <= hookY;
                scan_idx   <= 4'd0;
            end
            if (hit_fire) begin
                grabbed_type <= scan_slot.ltype;
                carry_idx    <= scan_idx;
            end
            if (do_deliver || clear_all) grabbed_type <= 3'd0;
            for (int i = 0; i < NUM_LOOTS; i++) begin
                if (clear_all) begin
                    slots[i].ltype <= LOOT_NONE;
                end else begin
                    if (do_load && load_idx == 4'(i))
                        slots[i] <= '{x: load_x, y: load_y, ltype: loot_type_t'(load_type)};
                    if (do_move && carry_idx == 4'(i)) begin
                        slots[i].x <= clamp_sub(hookX, HALF_TILE_W);
                        slots[i].y <= hookY;
                    end
                    if (do_deliver && carry_idx == 4'(i)) slots[i].ltype <= LOOT_NONE;
                end
            end
        end
    end

    assign carrying = (state == ST_CARRY);

endmodule

// File: tb/tb_loot_field_ctrl.sv
// Directed bench for loot_field_ctrl: pixel lookup, overlap priority,
// grab hit/miss, carry move/clamp, deliver, clear and reset.
module tb_loot_field_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame, clear_all, load_en, grab_req, deliver;
    logic [10:0] pixelX, pixelY, load_x, load_y, hookX, hookY;
    logic [3:0]  load_idx;
    logic [2:0]  load_type;
    logic [2:0]  loot_type, grabbed_type, delivered_type;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle, grab_hit, grab_miss, carrying, delivered;
    logic [4:0]  remaining;

    int checks = 0;
    int errors = 0;

    loot_field_ctrl #(.NUM_LOOTS(8), .TILE_NUMBER_OF_X_BITS(5), .TILE_NUMBER_OF_Y_BITS(5)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .clear_all(clear_all),
        .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
        .load_type(load_type), .grab_req(grab_req), .hookX(hookX), .hookY(hookY),
        .deliver(deliver), .loot_type(loot_type), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .grab_hit(grab_hit), .grab_miss(grab_miss),
        .grabbed_type(grabbed_type), .carrying(carrying), .delivered(delivered),
        .delivered_type(delivered_type), .remaining(remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slot(input logic [3:0] idx, input logic [10:0] x, input logic [10:0] y, input logic [2:0] t);
        load_en = 1'b1; load_idx = idx; load_x = x; load_y = y; load_type = t;
        tick();
        load_en = 1'b0;
    endtask

    task automatic drive_pixel(input logic [10:0] x, input logic [10:0] y);
        pixelX = x; pixelY = y;
        tick();
    endtask

    task automatic pulse_clear();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
    endtask

    // Issues grab_req and returns the number of further edges until the given pulse.
    task automatic grab_wait(input logic [10:0] hx, input logic [10:0] hy, input bit want_hit, output int cycles);
        hookX = hx; hookY = hy; grab_req = 1'b1;
        tick();
        grab_req = 1'b0;
        cycles = 0;
        while (((want_hit ? grab_hit : grab_miss) !== 1'b1) && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startOfFrame = 0; clear_all = 0; load_en = 0; grab_req = 0; deliver = 0;
        pixelX = 0; pixelY = 0; load_x = 0; load_y = 0; hookX = 0; hookY = 0;
        load_idx = 0; load_type = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (InsideRectangle !== 1'b0) begin errors++; $display("FAIL reset_inside: got %0d expected 0", InsideRectangle); end
        checks++; if (loot_type !== 3'd0) begin errors++; $display("FAIL reset_type: got %0d expected 0", loot_type); end
        checks++; if (carrying !== 1'b0) begin errors++; $display("FAIL reset_carrying: got %0d expected 0", carrying); end
        checks++; if (remaining !== 5'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        checks++; if ({grab_hit, grab_miss, delivered} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {grab_hit, grab_miss, delivered}); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_pixel();
        load_slot(4'd0, 11'd100, 11'd200, 3'd1);
        drive_pixel(11'd115, 11'd210);
        checks++; if (InsideRectangle !== 1'b1) begin errors++; $display("FAIL pix_inside: got %0d expected 1", InsideRectangle); end
        checks++; if (loot_type !== 3'd1) begin errors++; $display("FAIL pix_type: got %0d expected 1", loot_type); end
        checks++; if (offsetX !== 11'd15 || offsetY !== 11'd10) begin errors++; $display("FAIL pix_offset: got %0d,%0d expected 15,10", offsetX, offsetY); end
        drive_pixel(11'd132, 11'd210);
        checks++; if (InsideRectangle !== 1'b0 || loot_type !== 3'd0 || offsetX !== 11'd0) begin errors++; $display("FAIL pix_right_edge: got %0d/%0d/%0d expected 0/0/0", InsideRectangle, loot_type, offsetX); end
        drive_pixel(11'd131, 11'd231);
        checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd31 || offsetY !== 11'd31) begin errors++; $display("FAIL pix_corner: got %0d/%0d/%0d expected 1/31/31", InsideRectangle, offsetX, offsetY); end
        drive_pixel(11'd99, 11'd210);
        checks++; if (InsideRectangle !== 1'b0) begin errors++; $display("FAIL pix_left_edge: got %0d expected 0", InsideRectangle); end
        load_slot(4'd9, 11'd700, 11'd700, 3'd1);
        drive_pixel(11'd700, 11'd700);
        checks++; if (InsideRectangle !== 1'b0) begin errors++; $display("FAIL load_out_of_range: got %0d expected 0", InsideRectangle); end
        tick();
        checks++; if (remaining !== 5'd1) begin errors++; $display("FAIL pix_remaining: got %0d expected 1", remaining); end
    endtask

    task automatic test_overlap();
        pulse_clear();
        load_slot(4'd2, 11'd100, 11'd200, 3'd2);
        load_slot(4'd5, 11'd110, 11'd200, 3'd1);
        drive_pixel(11'd112, 11'd205);
        checks++; if (loot_type !== 3'd2 || offsetX !== 11'd12 || offsetY !== 11'd5) begin errors++; $display("FAIL overlap_low_wins: got %0d/%0d/%0d expected 2/12/5", loot_type, offsetX, offsetY); end
        drive_pixel(11'd135, 11'd205);
        checks++; if (loot_type !== 3'd1 || offsetX !== 11'd25) begin errors++; $display("FAIL overlap_upper_only: got %0d/%0d expected 1/25", loot_type, offsetX); end
        checks++; if (remaining !== 5'd2) begin errors++; $display("FAIL overlap_remaining: got %0d expected 2", remaining); end
    endtask

    task automatic test_grab_carry_deliver();
        int cyc;
        pulse_clear();
        load_slot(4'd3, 11'd300, 11'd50, 3'd2);
        grab_wait(11'd310, 11'd60, 1'b1, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL grab_hit_latency: got %0d expected 4", cyc); end
        checks++; if (grabbed_type !== 3'd2 || carrying !== 1'b1) begin errors++; $display("FAIL grab_hit_state: got %0d/%0d expected 2/1", grabbed_type, carrying); end
        hookX = 11'd400; hookY = 11'd300; startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        checks++; if (grab_hit !== 1'b0 || carrying !== 1'b1) begin errors++; $display("FAIL grab_hit_pulse: got %0d/%0d expected 0/1", grab_hit, carrying); end
        drive_pixel(11'd384, 11'd300);
        checks++; if (InsideRectangle !== 1'b1 || loot_type !== 3'd2 || offsetX !== 11'd0 || offsetY !== 11'd0) begin errors++; $display("FAIL carry_move: got %0d/%0d/%0d/%0d expected 1/2/0/0", InsideRectangle, loot_type, offsetX, offsetY); end
        checks++; if (remaining !== 5'd1) begin errors++; $display("FAIL carry_remaining: got %0d expected 1", remaining); end
        deliver = 1'b1;
        tick();
        deliver = 1'b0;
        checks++; if (delivered !== 1'b1 || delivered_type !== 3'd2) begin errors++; $display("FAIL deliver_pulse: got %0d/%0d expected 1/2", delivered, delivered_type); end
        checks++; if (grabbed_type !== 3'd0 || carrying !== 1'b0) begin errors++; $display("FAIL deliver_state: got %0d/%0d expected 0/0", grabbed_type, carrying); end
        tick();
        checks++; if (remaining !== 5'd0 || delivered !== 1'b0) begin errors++; $display("FAIL deliver_after: got %0d/%0d expected 0/0", remaining, delivered); end
        checks++; if (InsideRectangle !== 1'b0) begin errors++; $display("FAIL deliver_slot_empty: got %0d expected 0", InsideRectangle); end
    endtask

    task automatic test_grab_miss();
        int cyc;
        grab_wait(11'd0, 11'd0, 1'b0, cyc);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL grab_miss_latency: got %0d expected 8", cyc); end
        checks++; if (grab_hit !== 1'b0 || carrying !== 1'b0) begin errors++; $display("FAIL grab_miss_state: got %0d/%0d expected 0/0", grab_hit, carrying); end
        tick();
        checks++; if (grab_miss !== 1'b0) begin errors++; $display("FAIL grab_miss_pulse: got %0d expected 0", grab_miss); end
    endtask

    task automatic test_clear_during_scan();
        int pulses;
        load_slot(4'd0, 11'd500, 11'd400, 3'd1);
        hookX = 11'd510; hookY = 11'd410; grab_req = 1'b1;
        tick();
        grab_req = 1'b0;
        pulse_clear();
        checks++; if (grab_hit !== 1'b0 || carrying !== 1'b0 || grabbed_type !== 3'd0) begin errors++; $display("FAIL clear_scan_suppress: got %0d/%0d/%0d expected 0/0/0", grab_hit, carrying, grabbed_type); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grab_hit === 1'b1 || grab_miss === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL clear_scan_pulses: got %0d expected 0", pulses); end
        checks++; if (remaining !== 5'd0) begin errors++; $display("FAIL clear_scan_remaining: got %0d expected 0", remaining); end
    endtask

    task automatic test_reset_mid_carry();
        int cyc;
        load_slot(4'd1, 11'd50, 11'd60, 3'd1);
        pixelX = 11'd55; pixelY = 11'd65;
        grab_wait(11'd55, 11'd65, 1'b1, cyc);
        checks++; if (cyc !== 2 || carrying !== 1'b1) begin errors++; $display("FAIL rst_carry_setup: got %0d/%0d expected 2/1", cyc, carrying); end
        #2;
        resetN = 1'b0;
        #2;
        checks++; if ({InsideRectangle, loot_type, carrying, grabbed_type, grab_hit} !== 9'd0) begin errors++; $display("FAIL rst_carry_outputs: got %h expected 0", {InsideRectangle, loot_type, carrying, grabbed_type, grab_hit}); end
        checks++; if (remaining !== 5'd0 || offsetX !== 11'd0) begin errors++; $display("FAIL rst_carry_counts: got %0d/%0d expected 0/0", remaining, offsetX); end
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_clamp_and_ignored();
        int cyc;
        load_slot(4'd4, 11'd200, 11'd200, 3'd1);
        grab_wait(11'd205, 11'd205, 1'b1, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL clamp_grab_latency: got %0d expected 5", cyc); end
        hookX = 11'd5; hookY = 11'd100; startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        drive_pixel(11'd0, 11'd100);
        checks++; if (InsideRectangle !== 1'b1 || offsetX !== 11'd0 || loot_type !== 3'd1) begin errors++; $display("FAIL clamp_origin: got %0d/%0d/%0d expected 1/0/1", InsideRectangle, offsetX, loot_type); end
        drive_pixel(11'd32, 11'd100);
        checks++; if (InsideRectangle !== 1'b0) begin errors++; $display("FAIL clamp_width: got %0d expected 0", InsideRectangle); end
        load_slot(4'd6, 11'd600, 11'd600, 3'd2);
        grab_req = 1'b1; hookX = 11'd200; hookY = 11'd200;
        deliver = 1'b1; startOfFrame = 1'b1;
        tick();
        grab_req = 1'b0; deliver = 1'b0; startOfFrame = 1'b0;
        checks++; if (delivered !== 1'b1 || delivered_type !== 3'd1) begin errors++; $display("FAIL deliver_wins: got %0d/%0d expected 1/1", delivered, delivered_type); end
        drive_pixel(11'd600, 11'd600);
        checks++; if (InsideRectangle !== 1'b0 || carrying !== 1'b0) begin errors++; $display("FAIL load_ignored_carry: got %0d/%0d expected 0/0", InsideRectangle, carrying); end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_overlap();
        test_grab_carry_deliver();
        test_grab_miss();
        test_clear_during_scan();
        test_reset_mid_carry();
        test_clamp_and_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
